// File: rtl/hazard_unit_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : hazard_unit_n                                                  |
// | Brief   : RAW bypass/stall resolution, redirect flush, stall watchdog    |
// |           and saturating performance counters for the EX stage.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hazard_unit_n #(
  parameter int NREGS        = 32,
  parameter int FWD_STAGES   = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_MAX    = 16,
  parameter int CNT_W        = 16,
  localparam int AW          = $clog2(NREGS),
  localparam int SW          = $clog2(FWD_STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ex_valid,
  input  logic [AW-1:0]            ex_rs1,
  input  logic [AW-1:0]            ex_rs2,
  input  logic                     ex_use_rs1,
  input  logic                     ex_use_rs2,
  input  logic [FWD_STAGES-1:0]    stg_we,
  input  logic [FWD_STAGES*AW-1:0] stg_rd,
  input  logic [FWD_STAGES-1:0]    stg_ready,
  input  logic                     fwd_en,
  input  logic                     redirect,
  input  logic                     clr_cnt,
  output logic [SW-1:0]            src1,
  output logic [SW-1:0]            src2,
  output logic                     stall,
  output logic                     flush,
  output logic                     hang,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt,
  output logic [CNT_W-1:0]         fwd_cnt
);

  localparam int c_fl_w  = $clog2(FLUSH_CYCLES + 1);
  localparam int c_run_w = $clog2(STALL_MAX);
  localparam logic [c_fl_w-1:0]  c_fl_load  = c_fl_w'(FLUSH_CYCLES - 1);
  localparam logic [c_run_w-1:0] c_run_last = c_run_w'(STALL_MAX - 1);

  logic [AW-1:0]      w_addr [2];
  logic [1:0]         w_use;
  logic [SW-1:0]      w_src  [2];
  logic [1:0]         w_hazard;
  logic               w_flush;
  logic               w_stall;
  logic               w_fwd_evt;

  logic [c_fl_w-1:0]  r_fl_cnt;
  logic [c_run_w-1:0] r_run;
  logic               r_hang;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;
  logic [CNT_W-1:0]   r_fwd_cnt;

  assign w_addr[0] = ex_rs1;
  assign w_addr[1] = ex_rs2;
  assign w_use     = {ex_use_rs2, ex_use_rs1};

  // Scan oldest to youngest so the youngest matching stage is the last writer.
  for (genvar g = 0; g < 2; g++) begin : g_opnd
    logic          w_hit;
    logic          w_rdy;
    logic [SW-1:0] w_sel;
    logic          w_active;

    always_comb begin
      w_hit = 1'b0;
      w_rdy = 1'b0;
      w_sel = '0;
      for (int i = FWD_STAGES; i >= 1; i--) begin
        if (stg_we[i-1] && (stg_rd[i*AW-1 -: AW] == w_addr[g])) begin
          w_hit = 1'b1;
          w_rdy = stg_ready[i-1];
          w_sel = SW'(i);
        end
      end
    end

    assign w_active    = w_use[g] && (w_addr[g] != '0);
    assign w_hazard[g] = w_active && w_hit && (!fwd_en || !w_rdy);
    assign w_src[g]    = (w_active && w_hit && fwd_en && w_rdy) ? w_sel : '0;
  end

  // Outputs are held quiet while reset is asserted.
  assign w_flush = reset_n && (redirect || (r_fl_cnt != '0));
  assign w_stall = reset_n && ex_valid && !w_flush && (|w_hazard);

  assign flush = w_flush;
  assign stall = w_stall;
  assign src1  = reset_n ? w_src[0] : '0;
  assign src2  = reset_n ? w_src[1] : '0;
  assign hang  = r_hang;

  assign w_fwd_evt = ex_valid && !w_stall && !w_flush
                     && ((src1 != '0) || (src2 != '0));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A redirect always reloads, so back-to-back redirects extend the flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fl_cnt <= '0;
    end else if (redirect) begin
      r_fl_cnt <= c_fl_load;
    end else if (r_fl_cnt != '0) begin
      r_fl_cnt <= r_fl_cnt - 1'b1;
    end
  end

  // The run counter parks at its last value; hang is sticky from then on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run  <= '0;
      r_hang <= 1'b0;
    end else if (w_stall) begin
      if (r_run == c_run_last) begin
        r_hang <= 1'b1;
      end else begin
        r_run <= r_run + 1'b1;
      end
    end else begin
      r_run <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall)   r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush)   r_flush_cnt <= sat_inc(r_flush_cnt);
      if (w_fwd_evt) r_fwd_cnt   <= sat_inc(r_fwd_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign fwd_cnt   = r_fwd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_hazard_unit_n                                               |
// | Brief   : Directed vectors with a per-cycle expectation queue drained by |
// |           an independent monitor on the falling edge.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hazard_unit_n;

  localparam int NREGS = 32;
  localparam int FWD   = 2;
  localparam int AW    = 5;
  localparam int SW    = 2;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            ex_valid;
  logic [AW-1:0]   ex_rs1, ex_rs2;
  logic            ex_use_rs1, ex_use_rs2;
  logic [FWD-1:0]  stg_we;
  logic [FWD*AW-1:0] stg_rd;
  logic [FWD-1:0]  stg_ready;
  logic            fwd_en, redirect, clr_cnt;
  logic [SW-1:0]   src1, src2;
  logic            stall, flush, hang;
  logic [CW-1:0]   stall_cnt, flush_cnt, fwd_cnt;

  hazard_unit_n #(
    .NREGS(NREGS), .FWD_STAGES(FWD), .FLUSH_CYCLES(2), .STALL_MAX(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2),
    .stg_we(stg_we), .stg_rd(stg_rd), .stg_ready(stg_ready),
    .fwd_en(fwd_en), .redirect(redirect), .clr_cnt(clr_cnt),
    .src1(src1), .src2(src2), .stall(stall), .flush(flush), .hang(hang),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    nm;
    int       s1, s2, st, fl, hg, sc, fc, wc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic cmp(input string nm, input string f, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_errors++;
      $display("FAIL %s.%s got=%0d want=%0d", nm, f, act, want);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.nm, "src1",      int'(src1),      e.s1);
      cmp(e.nm, "src2",      int'(src2),      e.s2);
      cmp(e.nm, "stall",     int'(stall),     e.st);
      cmp(e.nm, "flush",     int'(flush),     e.fl);
      cmp(e.nm, "hang",      int'(hang),      e.hg);
      cmp(e.nm, "stall_cnt", int'(stall_cnt), e.sc);
      cmp(e.nm, "flush_cnt", int'(flush_cnt), e.fc);
      cmp(e.nm, "fwd_cnt",   int'(fwd_cnt),   e.wc);
    end
  end

  task automatic step(input string nm, input int s1, input int s2, input int st,
                      input int fl, input int hg, input int sc, input int fc, input int wc);
    exp_t e;
    e.nm = nm; e.s1 = s1; e.s2 = s2; e.st = st; e.fl = fl;
    e.hg = hg; e.sc = sc; e.fc = fc; e.wc = wc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic stages(input logic [1:0] we, input int rd1, input int rd2,
                        input logic [1:0] rdy);
    stg_we    = we;
    stg_rd    = {AW'(rd2), AW'(rd1)};
    stg_ready = rdy;
  endtask

  initial begin
    reset_n = 1'b0; ex_valid = 1'b1; ex_rs1 = 5'd5; ex_rs2 = 5'd0;
    ex_use_rs1 = 1'b1; ex_use_rs2 = 1'b0; fwd_en = 1'b1;
    redirect = 1'b1; clr_cnt = 1'b0;
    stages(2'b01, 5, 0, 2'b00);
    @(posedge clk);
    #1;

    // Reset holds everything quiet despite a redirect and a hazard.
    step("rst_a", 0,0,0,0,0, 0,0,0);
    step("rst_b", 0,0,0,0,0, 0,0,0);
    reset_n = 1'b1;
    step("rel_1", 0,0,0,1,0, 0,0,0);
    redirect = 1'b0;
    step("rel_2", 0,0,0,1,0, 0,1,0);
    step("rel_3", 0,0,1,0,0, 0,2,0);
    clr_cnt = 1'b1; ex_valid = 1'b0; stages(2'b00, 0, 0, 2'b00);
    step("rel_4", 0,0,0,0,0, 1,2,0);
    clr_cnt = 1'b0;
    step("rel_5", 0,0,0,0,0, 0,0,0);

    // Youngest-stage priority and x0 handling.
    ex_valid = 1'b1; ex_rs1 = 5'd5; ex_use_rs1 = 1'b1;
    stages(2'b11, 5, 5, 2'b11);
    step("pri_y", 1,0,0,0,0, 0,0,0);
    stages(2'b10, 5, 5, 2'b11);
    step("pri_o", 2,0,0,0,0, 0,0,1);
    ex_rs1 = 5'd0; stages(2'b11, 0, 0, 2'b11);
    step("pri_x0", 0,0,0,0,0, 0,0,2);
    ex_rs1 = 5'd5; ex_use_rs1 = 1'b0; stages(2'b11, 5, 5, 2'b11);
    step("pri_nouse", 0,0,0,0,0, 0,0,2);
    ex_valid = 1'b0; clr_cnt = 1'b1;
    step("pri_clr", 0,0,0,0,0, 0,0,2);
    clr_cnt = 1'b0;

    // Load-use: two stall cycles, then bypass from stage 1.
    ex_valid = 1'b1; ex_rs2 = 5'd7; ex_use_rs2 = 1'b1;
    stages(2'b01, 7, 0, 2'b00);
    step("ld_1", 0,0,1,0,0, 0,0,0);
    step("ld_2", 0,0,1,0,0, 1,0,0);
    stages(2'b01, 7, 0, 2'b01);
    step("ld_fwd", 0,1,0,0,0, 2,0,0);
    ex_valid = 1'b0; stages(2'b00, 0, 0, 2'b00);
    step("ld_cnt", 0,0,0,0,0, 2,0,1);
    clr_cnt = 1'b1;
    step("ld_clr", 0,0,0,0,0, 2,0,1);
    clr_cnt = 1'b0;

    // Redirect over a hazard, re-redirect in flush cycle 2.
    ex_valid = 1'b1; stages(2'b01, 7, 0, 2'b00); redirect = 1'b1;
    step("rd_1", 0,0,0,1,0, 0,0,0);
    step("rd_2", 0,0,0,1,0, 0,1,0);
    redirect = 1'b0;
    step("rd_3", 0,0,0,1,0, 0,2,0);
    step("rd_end", 0,0,1,0,0, 0,3,0);
    ex_valid = 1'b0; stages(2'b00, 0, 0, 2'b00); clr_cnt = 1'b1;
    step("rd_cnt", 0,0,0,0,0, 1,3,0);
    clr_cnt = 1'b0;

    // Interlock-only mode stalls on a ready match; watchdog trips after 4.
    fwd_en = 1'b0; ex_valid = 1'b1; ex_rs1 = 5'd9; ex_use_rs1 = 1'b1;
    ex_use_rs2 = 1'b0; stages(2'b10, 0, 9, 2'b11);
    step("il_1", 0,0,1,0,0, 0,0,0);
    step("il_2", 0,0,1,0,0, 1,0,0);
    step("il_3", 0,0,1,0,0, 2,0,0);
    step("il_4", 0,0,1,0,0, 3,0,0);
    stages(2'b00, 0, 0, 2'b00); fwd_en = 1'b1;
    step("wd_set", 0,0,0,0,1, 4,0,0);
    clr_cnt = 1'b1;
    step("wd_hold", 0,0,0,0,1, 4,0,0);
    clr_cnt = 1'b0;

    // Saturation of a 4-bit counter, then clear while stalled.
    stages(2'b01, 9, 0, 2'b00);
    for (int k = 1; k <= 20; k++) begin
      step("sat", 0,0,1,0,1, (k - 1 > 15) ? 15 : k - 1, 0,0);
    end
    clr_cnt = 1'b1;
    step("sat_top", 0,0,1,0,1, 15,0,0);
    clr_cnt = 1'b0;
    step("clr_0", 0,0,1,0,1, 0,0,0);
    step("clr_1", 0,0,1,0,1, 1,0,0);
    ex_valid = 1'b0;
    step("clr_2", 0,0,0,0,1, 2,0,0);

    // Reset mid-flush clears state; no flush resumes after release.
    redirect = 1'b1;
    step("mf_1", 0,0,0,1,1, 2,0,0);
    redirect = 1'b0; reset_n = 1'b0;
    step("mf_rst", 0,0,0,0,0, 0,0,0);
    reset_n = 1'b1;
    step("mf_rel", 0,0,0,0,0, 0,0,0);

    for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge clk);
    #1;
    cmp("drain", "pending", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
